// File: rtl/ball_pkg.sv
// Shared types and constants for the ball collision block.
// Latency: n/a (package only).
// Backpressure: n/a.
//
// Contents: 10-bit screen coordinate type, 11-bit extended type used for
// overflow-free box arithmetic, the collision FSM state enum, ball colour
// codes, and two helpers that build box edges without 10-bit wrap.
package ball_pkg;

  localparam int COORD_W = 10;
  localparam int EXT_W   = COORD_W + 1;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [EXT_W-1:0]   ext_t;

  typedef enum logic [1:0] {
    PLAY   = 2'd0,
    INVULN = 2'd1,
    OVER   = 2'd2
  } coll_state_t;

  localparam logic BALL_COLOR_RED  = 1'b1;
  localparam logic BALL_COLOR_BLUE = 1'b0;

  // Lower box edge: a - b in 11 bits, clamped at 0 instead of wrapping.
  function automatic ext_t sub_clamp(input coord_t a, input coord_t b);
    ext_t r;
    if (a >= b) r = {1'b0, a} - {1'b0, b};
    else        r = '0;
    return r;
  endfunction

  // Upper box edge: a + b widened to 11 bits so the carry is kept.
  function automatic ext_t add_ext(input coord_t a, input coord_t b);
    return {1'b0, a} + {1'b0, b};
  endfunction

endpackage

// File: rtl/box_overlap.sv
// Combinational test: does a square ball box intersect the obstacle box.
// Latency: zero cycles (pure combinational).
// Backpressure: none; evaluated every cycle.
//
// Ports:
//   ball_x, ball_y  ball centre
//   ball_s          ball half-size; ball box is [x-s, x+s] x [y-s, y+s]
//   obs_x, obs_y    obstacle top-left corner
//   obs_w, obs_h    obstacle extent; a zero extent never overlaps
//   obs_valid       obstacle present
//   overlap         inclusive intersection on both axes
module box_overlap
  import ball_pkg::*;
(
  input  coord_t ball_x,
  input  coord_t ball_y,
  input  coord_t ball_s,
  input  coord_t obs_x,
  input  coord_t obs_y,
  input  coord_t obs_w,
  input  coord_t obs_h,
  input  logic   obs_valid,
  output logic   overlap
);

  ext_t ball_l, ball_r, ball_t, ball_b;
  ext_t obs_l, obs_r, obs_t, obs_b;
  logic obs_present;
  logic x_hit, y_hit;

  // All edges are 11 bits wide so a box hugging the right or bottom border
  // (e.g. 1020 + 10) is not folded back onto the left/top of the screen.
  assign ball_l = sub_clamp(ball_x, ball_s);
  assign ball_r = add_ext(ball_x, ball_s);
  assign ball_t = sub_clamp(ball_y, ball_s);
  assign ball_b = add_ext(ball_y, ball_s);

  assign obs_l  = {1'b0, obs_x};
  assign obs_t  = {1'b0, obs_y};
  // The -1 can underflow only for a zero extent, which obs_present masks.
  assign obs_r  = add_ext(obs_x, obs_w) - ext_t'(1);
  assign obs_b  = add_ext(obs_y, obs_h) - ext_t'(1);

  assign obs_present = obs_valid && (obs_w != '0) && (obs_h != '0);

  assign x_hit = (ball_l <= obs_r) && (obs_l <= ball_r);
  assign y_hit = (ball_t <= obs_b) && (obs_t <= ball_b);

  assign overlap = obs_present && x_hit && y_hit;

endmodule

// File: rtl/ball_collision.sv
// Ball/obstacle collision tracker: hit pulses, lives, immunity blink, game over.
// Latency: one frame_clk edge from sampled overlap to Hit/HitColor/Lives; all outputs registered.
// Backpressure: none; every frame is evaluated, overlaps during immunity or after game over are dropped.
//
// Ports:
//   frame_clk, Reset       frame-rate clock, asynchronous active-high reset
//   RedX/RedY, BlueX/BlueY ball centres; BallS shared half-size
//   ObsX/ObsY/ObsW/ObsH    obstacle box; ObsValid marks it present
//   Lives                  remaining lives
//   Hit                    one-frame pulse per counted collision
//   HitColor               colour of last ball hit (1 red, 0 blue), held between hits
//   Flash                  renderer blink enable while immune
//   GameOver               level, lives exhausted
//
// Build option: define BALL_COLLISION_GODMODE_EN for god mode -- hits,
// immunity and Flash still happen, but Lives never drops and OVER is never
// reached.
module ball_collision
  import ball_pkg::*;
#(
  parameter int START_LIVES   = 3,
  parameter int INVULN_FRAMES = 60,
  parameter int FLASH_PERIOD  = 8
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  coord_t     RedX,
  input  coord_t     RedY,
  input  coord_t     BlueX,
  input  coord_t     BlueY,
  input  coord_t     BallS,
  input  coord_t     ObsX,
  input  coord_t     ObsY,
  input  coord_t     ObsW,
  input  coord_t     ObsH,
  input  logic       ObsValid,
  output logic [1:0] Lives,
  output logic       Hit,
  output logic       HitColor,
  output logic       Flash,
  output logic       GameOver
);

  localparam logic [1:0] LIVES_INIT = 2'(START_LIVES);
  localparam logic [7:0] INV_LOAD   = 8'(INVULN_FRAMES - 1);
  localparam logic [7:0] FLASH_LAST = 8'(FLASH_PERIOD - 1);

  logic red_ov, blue_ov, any_ov;

  coll_state_t state_q, state_d;
  logic [7:0]  inv_cnt_q, inv_cnt_d;
  logic [7:0]  flash_cnt_q, flash_cnt_d;
  logic [1:0]  lives_d;
  logic        hit_d, color_d, flash_d, over_d;

  box_overlap u_red_overlap (
    .ball_x    (RedX),
    .ball_y    (RedY),
    .ball_s    (BallS),
    .obs_x     (ObsX),
    .obs_y     (ObsY),
    .obs_w     (ObsW),
    .obs_h     (ObsH),
    .obs_valid (ObsValid),
    .overlap   (red_ov)
  );

  box_overlap u_blue_overlap (
    .ball_x    (BlueX),
    .ball_y    (BlueY),
    .ball_s    (BallS),
    .obs_x     (ObsX),
    .obs_y     (ObsY),
    .obs_w     (ObsW),
    .obs_h     (ObsH),
    .obs_valid (ObsValid),
    .overlap   (blue_ov)
  );

  assign any_ov = red_ov || blue_ov;

  always_comb begin
    state_d     = state_q;
    inv_cnt_d   = inv_cnt_q;
    flash_cnt_d = flash_cnt_q;
    lives_d     = Lives;
    hit_d       = 1'b0;
    color_d     = HitColor;
    flash_d     = Flash;
    over_d      = GameOver;

    unique case (state_q)
      PLAY: begin
        flash_d = 1'b0;
        if (any_ov) begin
          hit_d   = 1'b1;
          // Red wins a simultaneous hit; only one life is charged either way.
          color_d = red_ov ? BALL_COLOR_RED : BALL_COLOR_BLUE;
`ifdef BALL_COLLISION_GODMODE_EN
          lives_d     = LIVES_INIT;
          state_d     = INVULN;
          inv_cnt_d   = INV_LOAD;
          flash_cnt_d = '0;
          flash_d     = 1'b1;
`else
          if (Lives <= 2'd1) begin
            // Last life: go straight to OVER, no immunity window or blink.
            lives_d     = 2'd0;
            state_d     = OVER;
            over_d      = 1'b1;
            inv_cnt_d   = '0;
            flash_cnt_d = '0;
          end else begin
            lives_d     = Lives - 2'd1;
            state_d     = INVULN;
            inv_cnt_d   = INV_LOAD;
            flash_cnt_d = '0;
            flash_d     = 1'b1;
          end
`endif
        end
      end

      INVULN: begin
        if (inv_cnt_q == '0) begin
          state_d     = PLAY;
          flash_d     = 1'b0;
          flash_cnt_d = '0;
        end else begin
          inv_cnt_d = inv_cnt_q - 8'd1;
          // flash_cnt counts frames spent in the current Flash half-period.
          if (flash_cnt_q == FLASH_LAST) begin
            flash_d     = ~Flash;
            flash_cnt_d = '0;
          end else begin
            flash_cnt_d = flash_cnt_q + 8'd1;
          end
        end
      end

      OVER: begin
        lives_d = 2'd0;
        flash_d = 1'b0;
        over_d  = 1'b1;
      end

      default: begin
        state_d = PLAY;
        flash_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= PLAY;
      inv_cnt_q   <= '0;
      flash_cnt_q <= '0;
      Lives       <= LIVES_INIT;
      Hit         <= 1'b0;
      HitColor    <= 1'b0;
      Flash       <= 1'b0;
      GameOver    <= 1'b0;
    end else begin
      state_q     <= state_d;
      inv_cnt_q   <= inv_cnt_d;
      flash_cnt_q <= flash_cnt_d;
      Lives       <= lives_d;
      Hit         <= hit_d;
      HitColor    <= color_d;
      Flash       <= flash_d;
      GameOver    <= over_d;
    end
  end

endmodule

// File: tb/tb_ball_collision.sv
// Self-checking bench for ball_collision: frame-level game model plus directed vectors.
// Latency: model output for an edge is compared 3 time units after that edge.
// Backpressure: n/a.
module tb_ball_collision;

  localparam int START = 3;
  localparam int INV   = 60;
  localparam int FP    = 8;

  logic       frame_clk = 1'b0;
  logic       Reset;
  logic [9:0] RedX, RedY, BlueX, BlueY, BallS;
  logic [9:0] ObsX, ObsY, ObsW, ObsH;
  logic       ObsValid;
  logic [1:0] Lives;
  logic       Hit, HitColor, Flash, GameOver;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  always #5 frame_clk = ~frame_clk;

  ball_collision #(
    .START_LIVES   (START),
    .INVULN_FRAMES (INV),
    .FLASH_PERIOD  (FP)
  ) dut (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .RedX      (RedX),
    .RedY      (RedY),
    .BlueX     (BlueX),
    .BlueY     (BlueY),
    .BallS     (BallS),
    .ObsX      (ObsX),
    .ObsY      (ObsY),
    .ObsW      (ObsW),
    .ObsH      (ObsH),
    .ObsValid  (ObsValid),
    .Lives     (Lives),
    .Hit       (Hit),
    .HitColor  (HitColor),
    .Flash     (Flash),
    .GameOver  (GameOver)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Expected values that differ in god mode.
  function automatic int el(input int v);
`ifdef BALL_COLLISION_GODMODE_EN
    return START;
`else
    return v;
`endif
  endfunction

  function automatic int eg(input int normal, input int god);
`ifdef BALL_COLLISION_GODMODE_EN
    return god;
`else
    return normal;
`endif
  endfunction

  // Plain integer box intersection; no bit widths involved.
  function automatic bit model_ovl(input int x, input int y, input int s,
                                   input int ox, input int oy, input int ow,
                                   input int oh, input bit v);
    int bl, bt;
    if (!v || ow == 0 || oh == 0) return 1'b0;
    bl = (x - s < 0) ? 0 : x - s;
    bt = (y - s < 0) ? 0 : y - s;
    return (bl <= ox + ow - 1) && (ox <= x + s) &&
           (bt <= oy + oh - 1) && (oy <= y + s);
  endfunction

  // Game model: frame number n, frame of the last counted hit, lives.
  int n        = 0;
  int last_hit = -100000;
  int m_lives  = START;
  bit m_hit    = 1'b0;
  bit m_color  = 1'b0;
  bit m_flash  = 1'b0;
  bit m_over   = 1'b0;
  bit m_r, m_b;
  int age;

  always @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      n        = 0;
      last_hit = -100000;
      m_lives  = START;
      m_hit    = 1'b0;
      m_color  = 1'b0;
      m_flash  = 1'b0;
      m_over   = 1'b0;
    end else begin
      n++;
      m_r   = model_ovl(RedX, RedY, BallS, ObsX, ObsY, ObsW, ObsH, ObsValid);
      m_b   = model_ovl(BlueX, BlueY, BallS, ObsX, ObsY, ObsW, ObsH, ObsValid);
      m_hit = 1'b0;
      // Immune for INV frames after a hit.
      if (!m_over && (n - last_hit) > INV && (m_r || m_b)) begin
        m_hit    = 1'b1;
        m_color  = m_r;
        last_hit = n;
`ifndef BALL_COLLISION_GODMODE_EN
        if (m_lives > 0) m_lives--;
        if (m_lives == 0) m_over = 1'b1;
`endif
      end
      age     = n - last_hit;
      m_flash = !m_over && (age < INV) && (((age / FP) % 2) == 0);
    end
  end

  always @(posedge frame_clk) begin
    #3;
    if (cmp_en && !Reset) begin
      chk("model_lives",    Lives,    m_lives);
      chk("model_hit",      Hit,      m_hit);
      chk("model_hitcolor", HitColor, m_color);
      chk("model_flash",    Flash,    m_flash);
      chk("model_gameover", GameOver, m_over);
    end
  end

  task automatic step();
    @(posedge frame_clk);
    #4;
  endtask

  task automatic steps(input int k);
    repeat (k) step();
  endtask

  task automatic set_obs(input int x, input int y, input int w, input int h, input bit v);
    ObsX = 10'(x); ObsY = 10'(y); ObsW = 10'(w); ObsH = 10'(h); ObsValid = v;
  endtask

  task automatic set_red(input int x, input int y);
    RedX = 10'(x); RedY = 10'(y);
  endtask

  task automatic set_blue(input int x, input int y);
    BlueX = 10'(x); BlueY = 10'(y);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_lives"},    Lives,    START);
    chk({tag, "_hit"},      Hit,      0);
    chk({tag, "_flash"},    Flash,    0);
    chk({tag, "_gameover"}, GameOver, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int extra;
    set_red(100, 100);
    set_blue(500, 100);
    BallS = 10'd4;
    set_obs(0, 0, 0, 0, 1'b0);
    Reset = 1'b1;
    #1;
    chk_reset_state("por");
    chk("por_hitcolor", HitColor, 0);
    @(negedge frame_clk);
    @(negedge frame_clk);
    Reset  = 1'b0;
    cmp_en = 1'b1;
    steps(3);
    chk("idle_hit", Hit, 0);

    // Single red hit, then overlap held through the immunity window.
    @(negedge frame_clk);
    set_obs(398, 230, 10, 10, 1'b1);
    set_red(400, 240);
    step();
    chk("red_hit",      Hit,      1);
    chk("red_color",    HitColor, 1);
    chk("red_lives",    Lives,    el(2));
    chk("red_flash",    Flash,    1);
    step();
    chk("red_pulse_end", Hit, 0);
    extra = 0;
    for (int k = 2; k <= 60; k++) begin
      step();
      if (Hit) extra++;
      if (k == 7)  chk("flash_k7",  Flash, 1);
      if (k == 8)  chk("flash_k8",  Flash, 0);
      if (k == 16) chk("flash_k16", Flash, 1);
      if (k == 60) chk("flash_k60", Flash, 0);
    end
    chk("immune_no_hits", extra, 0);
    step();
    chk("rehit_f61",       Hit,   1);
    chk("rehit_f61_lives", Lives, el(1));

    // Wait out immunity, then both balls hit on the last life.
    @(negedge frame_clk);
    ObsValid = 1'b0;
    steps(61);
    @(negedge frame_clk);
    set_blue(402, 240);
    ObsValid = 1'b1;
    step();
    chk("both_hit",      Hit,      1);
    chk("both_color",    HitColor, 1);
    chk("both_lives",    Lives,    el(0));
    chk("both_gameover", GameOver, eg(1, 0));
    chk("both_flash",    Flash,    eg(0, 1));
    extra = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (Hit) extra++;
    end
    chk("over_no_hits",  extra,    0);
    chk("over_gameover", GameOver, eg(1, 0));

    // Reset out of OVER; first edge afterwards samples a blue overlap.
    @(negedge frame_clk);
    Reset = 1'b1;
    #1;
    chk_reset_state("rst_over");
    set_red(100, 100);
    @(negedge frame_clk);
    Reset = 1'b0;
    step();
    chk("blue_hit",   Hit,      1);
    chk("blue_color", HitColor, 0);
    chk("blue_lives", Lives,    el(2));
    @(negedge frame_clk);
    ObsValid = 1'b0;
    steps(61);
    chk("color_hold", HitColor, 0);
    @(negedge frame_clk);
    set_red(400, 240);
    ObsValid = 1'b1;
    step();
    chk("both2_hit",   Hit,      1);
    chk("both2_color", HitColor, 1);
    chk("both2_lives", Lives,    el(1));
    steps(3);
    chk("mid_inv_flash", Flash, 1);
    @(negedge frame_clk);
    Reset = 1'b1;
    #1;
    chk_reset_state("rst_inv");

    // Boundary geometry.
    set_obs(1020, 99, 10, 10, 1'b1);
    set_red(3, 100);
    set_blue(500, 500);
    BallS = 10'd1;
    @(negedge frame_clk);
    Reset = 1'b0;
    step();
    chk("far_right_obs_no_hit", Hit, 0);
    @(negedge frame_clk);
    BallS = 10'd4;
    set_red(400, 240);
    set_obs(398, 230, 0, 10, 1'b1);
    step();
    chk("zero_w_no_hit", Hit, 0);
    @(negedge frame_clk);
    set_obs(398, 230, 10, 0, 1'b1);
    step();
    chk("zero_h_no_hit", Hit, 0);
    @(negedge frame_clk);
    set_obs(398, 230, 10, 10, 1'b0);
    step();
    chk("invalid_no_hit", Hit, 0);
    chk("no_hit_lives",   Lives, START);
    @(negedge frame_clk);
    set_red(2, 100);
    set_obs(0, 100, 1, 1, 1'b1);
    step();
    chk("clamp_hit",   Hit,   1);
    chk("clamp_lives", Lives, el(2));
    @(negedge frame_clk);
    ObsValid = 1'b0;
    steps(61);
    @(negedge frame_clk);
    set_red(1023, 100);
    set_obs(1020, 98, 10, 10, 1'b1);
    step();
    chk("edge_1023_hit",   Hit,   1);
    chk("edge_1023_lives", Lives, el(1));
    @(negedge frame_clk);
    ObsValid = 1'b0;
    steps(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
